// File: rtl/ifu_fetch_pkg.sv
// Shared opcodes and state encoding for the instruction fetch unit.
package ifu_fetch_pkg;

  localparam logic [6:0] OPCODE_JAL  = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR = 7'b1100111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_RSP,
    ST_DROP,
    ST_WAIT_JALR,
    ST_HALT
  } ifu_state_e;

endpackage

// File: rtl/ifu_minidec.sv
// Combinational mini-decode: flags JAL/JALR and extracts the J-type immediate.
module ifu_minidec
  import ifu_fetch_pkg::*;
#(
  parameter int PC_SIZE    = 32,
  parameter int INSTR_SIZE = 32
) (
  input  logic [INSTR_SIZE-1:0] instr,
  output logic                  is_jal,
  output logic                  is_jalr,
  output logic [PC_SIZE-1:0]    j_imm
);

  logic unused_rd;

  assign is_jal    = (instr[6:0] == OPCODE_JAL);
  assign is_jalr   = (instr[6:0] == OPCODE_JALR);
  assign j_imm     = {{(PC_SIZE-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  assign unused_rd = ^instr[11:7];

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one outstanding fetch at a time and
// buffers a single instruction (with PC, prediction and fault) for decode.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int                 PC_SIZE    = 32,
  parameter int                 INSTR_SIZE = 32,
  parameter logic [PC_SIZE-1:0] RESET_PC   = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ifu_req_valid,
  input  logic                  ifu_req_ready,
  output logic [PC_SIZE-1:0]    ifu_req_addr,
  input  logic                  ifu_rsp_valid,
  output logic                  ifu_rsp_ready,
  input  logic [INSTR_SIZE-1:0] ifu_rsp_instr,
  input  logic                  ifu_rsp_err,
  output logic                  o_ir_valid,
  input  logic                  o_ir_ready,
  output logic [INSTR_SIZE-1:0] o_ir_instr,
  output logic [PC_SIZE-1:0]    o_ir_pc,
  output logic                  o_prdt_taken,
  output logic                  o_ir_err,
  input  logic                  exu_redirect_valid,
  input  logic [PC_SIZE-1:0]    exu_redirect_pc
);

  localparam logic [PC_SIZE-1:0] ALIGN_MASK = ~PC_SIZE'(3);

  ifu_state_e              state_q, state_d;
  logic [PC_SIZE-1:0]      pc_q, pc_d;
  logic                    ir_valid_q, ir_valid_d;
  logic [INSTR_SIZE-1:0]   ir_instr_q, ir_instr_d;
  logic [PC_SIZE-1:0]      ir_pc_q, ir_pc_d;
  logic                    prdt_q, prdt_d;
  logic                    ir_err_q, ir_err_d;

  logic                    is_jal, is_jalr;
  logic [PC_SIZE-1:0]      j_imm;
  logic                    redirect;
  logic                    rsp_hs;
  logic                    ir_load;
  logic                    unused_redir_lo;

  ifu_minidec #(
    .PC_SIZE    (PC_SIZE),
    .INSTR_SIZE (INSTR_SIZE)
  ) u_minidec (
    .instr   (ifu_rsp_instr),
    .is_jal  (is_jal),
    .is_jalr (is_jalr),
    .j_imm   (j_imm)
  );

  assign unused_redir_lo = ^exu_redirect_pc[1:0];

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_valid_d    = ir_valid_q;
    ir_instr_d    = ir_instr_q;
    ir_pc_d       = ir_pc_q;
    prdt_d        = prdt_q;
    ir_err_d      = ir_err_q;
    ifu_req_valid = 1'b0;
    ifu_rsp_ready = 1'b0;
    rsp_hs        = 1'b0;
    ir_load       = 1'b0;
    redirect      = exu_redirect_valid && (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        ifu_req_valid = 1'b1;
        // An accept coinciding with a redirect still leaves a response in flight.
        if (redirect)           state_d = ifu_req_ready ? ST_DROP : ST_REQ;
        else if (ifu_req_ready) state_d = ST_WAIT_RSP;
      end
      ST_WAIT_RSP: begin
        ifu_rsp_ready = ~ir_valid_q | o_ir_ready;
        rsp_hs        = ifu_rsp_valid & ifu_rsp_ready;
        if (redirect) begin
          state_d = rsp_hs ? ST_REQ : ST_DROP;
        end else if (rsp_hs) begin
          ir_load = 1'b1;
          if (ifu_rsp_err) begin
            state_d = ST_HALT;
          end else if (is_jal) begin
            pc_d    = (pc_q + j_imm) & ALIGN_MASK;
            state_d = ST_REQ;
          end else if (is_jalr) begin
            state_d = ST_WAIT_JALR;
          end else begin
            pc_d    = pc_q + PC_SIZE'(4);
            state_d = ST_REQ;
          end
        end
      end
      ST_DROP: begin
        ifu_rsp_ready = 1'b1;
        if (ifu_rsp_valid) state_d = ST_REQ;
      end
      ST_WAIT_JALR, ST_HALT: begin
        if (redirect) state_d = ST_REQ;
      end
      default: state_d = ST_IDLE;
    endcase

    if (redirect) pc_d = exu_redirect_pc & ALIGN_MASK;

    if (redirect)        ir_valid_d = 1'b0;
    else if (ir_load)    ir_valid_d = 1'b1;
    else if (o_ir_ready) ir_valid_d = 1'b0;

    if (ir_load) begin
      ir_instr_d = ifu_rsp_instr;
      ir_pc_d    = pc_q;
      prdt_d     = is_jal & ~ifu_rsp_err;
      ir_err_d   = ifu_rsp_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      ir_valid_q <= 1'b0;
      ir_instr_q <= '0;
      ir_pc_q    <= '0;
      prdt_q     <= 1'b0;
      ir_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_valid_q <= ir_valid_d;
      ir_instr_q <= ir_instr_d;
      ir_pc_q    <= ir_pc_d;
      prdt_q     <= prdt_d;
      ir_err_q   <= ir_err_d;
    end
  end

  assign ifu_req_addr = pc_q;
  assign o_ir_valid   = ir_valid_q;
  assign o_ir_instr   = ir_instr_q;
  assign o_ir_pc      = ir_pc_q;
  assign o_prdt_taken = prdt_q;
  assign o_ir_err     = ir_err_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: sequential fetch, JAL/JALR, redirects, backpressure, faults.
module tb_ifu_fetch;

  localparam logic [31:0] ADDI = 32'h0010_0093;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_rsp_valid, ifu_rsp_ready;
  logic [31:0] ifu_rsp_instr;
  logic        ifu_rsp_err;
  logic        o_ir_valid, o_ir_ready;
  logic [31:0] o_ir_instr, o_ir_pc;
  logic        o_prdt_taken, o_ir_err;
  logic        exu_redirect_valid;
  logic [31:0] exu_redirect_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ifu_fetch dut (
    .clk                (clk),
    .rst                (rst),
    .ifu_req_valid      (ifu_req_valid),
    .ifu_req_ready      (ifu_req_ready),
    .ifu_req_addr       (ifu_req_addr),
    .ifu_rsp_valid      (ifu_rsp_valid),
    .ifu_rsp_ready      (ifu_rsp_ready),
    .ifu_rsp_instr      (ifu_rsp_instr),
    .ifu_rsp_err        (ifu_rsp_err),
    .o_ir_valid         (o_ir_valid),
    .o_ir_ready         (o_ir_ready),
    .o_ir_instr         (o_ir_instr),
    .o_ir_pc            (o_ir_pc),
    .o_prdt_taken       (o_prdt_taken),
    .o_ir_err           (o_ir_err),
    .exu_redirect_valid (exu_redirect_valid),
    .exu_redirect_pc    (exu_redirect_pc)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; ifu_rsp_instr = '0; ifu_rsp_err = 1'b0;
    o_ir_ready = 1'b1; exu_redirect_valid = 1'b0; exu_redirect_pc = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits (bounded) for a request, accepts it, returns at the negedge in WAIT_RSP.
  task automatic accept_req(output bit got, output logic [31:0] addr);
    got = 1'b0; addr = 'x;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (ifu_req_valid) begin got = 1'b1; addr = ifu_req_addr; end
    end
    if (got) begin
      ifu_req_ready = 1'b1;
      @(negedge clk);
      ifu_req_ready = 1'b0;
    end
  endtask

  // Full fetch: accept, respond, return at the negedge after the response handshake.
  task automatic fetch(input logic [31:0] instr, input logic err,
                       output bit got, output logic [31:0] addr);
    bit hs;
    accept_req(got, addr);
    if (!got) return;
    ifu_rsp_valid = 1'b1; ifu_rsp_instr = instr; ifu_rsp_err = err;
    hs = 1'b0;
    for (int i = 0; i < 20 && !hs; i++) begin
      if (ifu_rsp_ready) hs = 1'b1;
      else @(negedge clk);
    end
    if (!hs) got = 1'b0;
    @(negedge clk);
    ifu_rsp_valid = 1'b0; ifu_rsp_err = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    exu_redirect_valid = 1'b1; exu_redirect_pc = pc;
    @(negedge clk);
    exu_redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({ifu_req_valid, ifu_rsp_ready, o_ir_valid, o_prdt_taken, o_ir_err} !== 5'b0 ||
        o_ir_instr !== 32'h0 || o_ir_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got req_v=%b rsp_r=%b ir_v=%b prdt=%b err=%b instr=%h pc=%h want all 0",
               ifu_req_valid, ifu_rsp_ready, o_ir_valid, o_prdt_taken, o_ir_err, o_ir_instr, o_ir_pc);
    end
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    bit got; logic [31:0] addr;
    do_reset();
    fetch(ADDI, 1'b0, got, addr);
    checks++;
    if (!got || addr !== 32'h8000_0000) begin
      errors++; $display("FAIL seq_addr0 got %h (ok=%0d) want 80000000", addr, got);
    end
    checks++;
    if (o_ir_valid !== 1'b1 || o_ir_pc !== 32'h8000_0000 || o_ir_instr !== ADDI || o_prdt_taken !== 1'b0) begin
      errors++; $display("FAIL seq_ir0 got v=%b pc=%h instr=%h prdt=%b want 1 80000000 %h 0",
                         o_ir_valid, o_ir_pc, o_ir_instr, o_prdt_taken, ADDI);
    end
    fetch(ADDI, 1'b0, got, addr);
    checks++;
    if (!got || addr !== 32'h8000_0004) begin
      errors++; $display("FAIL seq_addr1 got %h (ok=%0d) want 80000004", addr, got);
    end
    checks++;
    if (o_ir_valid !== 1'b1 || o_ir_pc !== 32'h8000_0004 || o_prdt_taken !== 1'b0) begin
      errors++; $display("FAIL seq_ir1 got v=%b pc=%h prdt=%b want 1 80000004 0", o_ir_valid, o_ir_pc, o_prdt_taken);
    end
  endtask

  task automatic test_jal();
    bit got; logic [31:0] addr;
    do_reset();
    fetch(32'h0100_006F, 1'b0, got, addr);
    checks++;
    if (o_ir_valid !== 1'b1 || o_prdt_taken !== 1'b1 || o_ir_pc !== 32'h8000_0000) begin
      errors++; $display("FAIL jal_ir got v=%b prdt=%b pc=%h want 1 1 80000000", o_ir_valid, o_prdt_taken, o_ir_pc);
    end
    fetch(ADDI, 1'b0, got, addr);
    checks++;
    if (!got || addr !== 32'h8000_0010) begin
      errors++; $display("FAIL jal_target got %h (ok=%0d) want 80000010", addr, got);
    end
    checks++;
    if (o_prdt_taken !== 1'b0 || o_ir_pc !== 32'h8000_0010) begin
      errors++; $display("FAIL jal_after got prdt=%b pc=%h want 0 80000010", o_prdt_taken, o_ir_pc);
    end
  endtask

  task automatic test_jalr();
    bit got; logic [31:0] addr; int reqs;
    do_reset();
    fetch(32'h0000_8067, 1'b0, got, addr);
    checks++;
    if (o_ir_valid !== 1'b1 || o_ir_instr !== 32'h0000_8067 || o_prdt_taken !== 1'b0) begin
      errors++; $display("FAIL jalr_ir got v=%b instr=%h prdt=%b want 1 00008067 0", o_ir_valid, o_ir_instr, o_prdt_taken);
    end
    reqs = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ifu_req_valid) reqs++;
    end
    checks++;
    if (reqs !== 0) begin
      errors++; $display("FAIL jalr_stall got %0d request cycles want 0", reqs);
    end
    redirect_to(32'h8000_0102);
    fetch(ADDI, 1'b0, got, addr);
    checks++;
    if (!got || addr !== 32'h8000_0100) begin
      errors++; $display("FAIL jalr_target got %h (ok=%0d) want 80000100", addr, got);
    end
  endtask

  task automatic test_redirect();
    bit got; logic [31:0] addr;
    do_reset();
    // Redirect while a request is pending but not yet accepted.
    @(negedge clk);
    redirect_to(32'h8000_0300);
    checks++;
    if (ifu_req_valid !== 1'b1 || ifu_req_addr !== 32'h8000_0300) begin
      errors++; $display("FAIL redir_req got v=%b addr=%h want 1 80000300", ifu_req_valid, ifu_req_addr);
    end
    // Redirect while waiting for the response: stale response must be dropped.
    accept_req(got, addr);
    redirect_to(32'h8000_0200);
    checks++;
    if (ifu_rsp_ready !== 1'b1 || ifu_req_valid !== 1'b0) begin
      errors++; $display("FAIL redir_drop got rsp_r=%b req_v=%b want 1 0", ifu_rsp_ready, ifu_req_valid);
    end
    ifu_rsp_valid = 1'b1; ifu_rsp_instr = 32'hDEAD_0013;
    @(negedge clk);
    ifu_rsp_valid = 1'b0;
    checks++;
    if (o_ir_valid !== 1'b0) begin
      errors++; $display("FAIL redir_stale got ir_valid=%b want 0", o_ir_valid);
    end
    checks++;
    if (ifu_req_valid !== 1'b1 || ifu_req_addr !== 32'h8000_0200) begin
      errors++; $display("FAIL redir_next got v=%b addr=%h want 1 80000200", ifu_req_valid, ifu_req_addr);
    end
  endtask

  task automatic test_backpressure_err();
    bit got; logic [31:0] addr; int reqs;
    do_reset();
    o_ir_ready = 1'b0;
    fetch(ADDI, 1'b0, got, addr);
    accept_req(got, addr);
    checks++;
    if (!got || addr !== 32'h8000_0004) begin
      errors++; $display("FAIL bp_addr got %h (ok=%0d) want 80000004", addr, got);
    end
    ifu_rsp_valid = 1'b1; ifu_rsp_instr = 32'h0000_0013; ifu_rsp_err = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (o_ir_valid !== 1'b1 || o_ir_instr !== ADDI || o_ir_pc !== 32'h8000_0000 || ifu_rsp_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold[%0d] got v=%b instr=%h pc=%h rsp_r=%b want 1 %h 80000000 0",
                           i, o_ir_valid, o_ir_instr, o_ir_pc, ifu_rsp_ready, ADDI);
      end
      @(negedge clk);
    end
    o_ir_ready = 1'b1;
    @(negedge clk);
    ifu_rsp_valid = 1'b0; ifu_rsp_err = 1'b0;
    checks++;
    if (o_ir_valid !== 1'b1 || o_ir_err !== 1'b1 || o_ir_pc !== 32'h8000_0004 || o_prdt_taken !== 1'b0) begin
      errors++; $display("FAIL err_ir got v=%b err=%b pc=%h prdt=%b want 1 1 80000004 0",
                         o_ir_valid, o_ir_err, o_ir_pc, o_prdt_taken);
    end
    reqs = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ifu_req_valid) reqs++;
    end
    checks++;
    if (reqs !== 0) begin
      errors++; $display("FAIL err_halt got %0d request cycles want 0", reqs);
    end
    // Trap redirect to the top of the address space exercises the +4 wrap.
    redirect_to(32'hFFFF_FFFF);
    fetch(ADDI, 1'b0, got, addr);
    checks++;
    if (!got || addr !== 32'hFFFF_FFFC || o_ir_err !== 1'b0) begin
      errors++; $display("FAIL trap_addr got %h err=%b (ok=%0d) want fffffffc 0", addr, o_ir_err, got);
    end
    fetch(ADDI, 1'b0, got, addr);
    checks++;
    if (!got || addr !== 32'h0000_0000 || o_ir_pc !== 32'h0000_0000) begin
      errors++; $display("FAIL wrap_addr got %h pc=%h (ok=%0d) want 00000000", addr, o_ir_pc, got);
    end
  endtask

  initial begin
    rst = 1'b1;
    ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; ifu_rsp_instr = '0; ifu_rsp_err = 1'b0;
    o_ir_ready = 1'b1; exu_redirect_valid = 1'b0; exu_redirect_pc = '0;
    test_reset();
    test_sequential();
    test_jal();
    test_jalr();
    test_redirect();
    test_backpressure_err();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit. Producer side of the decode interface: owns the PC, issues single-outstanding fetch requests to instruction memory, and buffers one fetched instruction with its PC and prediction bit for exu_decode.
- A mini-decode statically predicts JAL as taken. On JALR, fetch stalls until the EXU returns the resolved target on the redirect port.

Parameters:
- PC_SIZE, 32, PC and address width.
- INSTR_SIZE, 32, instruction width.
- RESET_PC, 32'h8000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- ifu_req_valid  out  1  fetch request valid.
- ifu_req_ready  in  1  memory accepts request.
- ifu_req_addr  out  PC_SIZE  fetch address; bits [1:0] always 0.
- ifu_rsp_valid  in  1  response valid.
- ifu_rsp_ready  out  1  IFU accepts response.
- ifu_rsp_instr  in  INSTR_SIZE  fetched word.
- ifu_rsp_err  in  1  bus error on fetch.
- o_ir_valid  out  1  buffered instruction valid to decode.
- o_ir_ready  in  1  decode consumes instruction.
- o_ir_instr  out  INSTR_SIZE  instruction to decode.
- o_ir_pc  out  PC_SIZE  PC of the instruction.
- o_prdt_taken  out  1  JAL predicted taken.
- o_ir_err  out  1  fetch fault attached to the instruction.
- exu_redirect_valid  in  1  EXU redirect or flush.
- exu_redirect_pc  in  PC_SIZE  new PC; bits [1:0] ignored and forced 0.

Behaviour:
- Reset: state=IDLE, pc_r=RESET_PC. All valid/ready outputs 0. o_ir_instr, o_ir_pc, o_prdt_taken, o_ir_err = 0. Any in-flight response is forgotten.
- States: IDLE, REQ, WAIT_RSP, DROP, WAIT_JALR, HALT.
- IDLE: transitions to REQ the next cycle.
- REQ: ifu_req_valid=1 and ifu_req_addr=pc_r, held stable until ifu_req_ready. On accept, go to WAIT_RSP.
- WAIT_RSP: ifu_rsp_ready = (~o_ir_valid | o_ir_ready). On response handshake:
  - Load the IR buffer with instr, pc_r, and err.
  - JAL (opcode 1101111): pc_r <= pc_r + j_imm, o_prdt_taken=1, go to REQ.
  - JALR (opcode 1100111): go to WAIT_JALR; pc_r unchanged.
  - err=1: go to HALT.
  - Otherwise: pc_r <= pc_r + 4 (mod 2^PC_SIZE, wraps 0xFFFF_FFFC -> 0), go to REQ.
- Minimum latency: request accept to o_ir_valid is 1 cycle after the response handshake, because the IR is registered.
- IR buffer handshake:
  - o_ir_valid clears on o_ir_ready unless a new response loads in the same cycle.
  - Outputs are held stable while valid and not ready.
- WAIT_JALR: no requests issued; waits for exu_redirect_valid.
- HALT: no requests issued until exu_redirect_valid (trap redirect).
- Redirect (highest priority, any state except IDLE):
  - pc_r <= redirect_pc & ~3, and the IR buffer is flushed: o_ir_valid=0 next cycle, even if o_ir_ready is high in the same cycle.
  - In REQ: go to REQ with the new address the next cycle. A request accepted in the same cycle counts as outstanding, so go to DROP.
  - In WAIT_RSP: go to DROP. A response arriving in the same cycle is consumed and discarded; go to REQ instead.
- DROP: ifu_rsp_ready=1. The response is discarded with no IR load, then go to REQ. A further redirect while in DROP updates pc_r only.
- At most one request outstanding. ifu_req_valid is 0 in every state except REQ.
- Reset mid-transaction: return to IDLE. The memory side must tolerate the abandoned request (system-level rule).

Decomposition:
- defines.v gains PC_SIZE, INSTR_SIZE, RESET_PC, OPCODE_JAL, OPCODE_JALR, and the IFU state encodings.
- Sub-module ifu_minidec is combinational: instr -> is_jal, is_jalr, j_imm.
- All flops use sirv_gnrl_dfflr / dffr.

Test Plan:
- Sequential fetch: reset, memory returns ADDI at 0x8000_0000 and 0x8000_0004 with 1-cycle response -> requests at 0x8000_0000 then 0x8000_0004; o_ir_pc matches each request; o_prdt_taken=0.
- JAL: rsp 0x0100_006F (jal x0,+16) at 0x8000_0000 -> next ifu_req_addr=0x8000_0010; o_prdt_taken=1 with that instruction.
- JALR: rsp 0x0000_8067 -> no requests for 5 cycles; redirect_pc=0x8000_0102 -> next request at 0x8000_0100.
- Redirect in WAIT_RSP: redirect to 0x8000_0200, then stale response arrives -> response discarded; o_ir_valid stays 0; next request at 0x8000_0200.
- Backpressure and error: o_ir_ready=0 for 4 cycles -> o_ir_* stable and ifu_rsp_ready=0. Then rsp_err=1 -> o_ir_err=1; no further requests until redirect.
